// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_pkg
// Description : Shared definitions for the key-press counter and the LED
//               pattern generator: mode encoding and default step period.
// Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

  typedef logic [2:0] mode_t;

  // Mode encoding, shared with the key counter that produces the held value.
  localparam mode_t MODE_OFF    = 3'd0;
  localparam mode_t MODE_ON     = 3'd1;
  localparam mode_t MODE_RUN_L  = 3'd2;
  localparam mode_t MODE_RUN_R  = 3'd3;
  localparam mode_t MODE_BOUNCE = 3'd4;
  localparam mode_t MODE_BLINK  = 3'd5;
  localparam mode_t MODE_COUNT  = 3'd6;
  localparam mode_t MODE_FILL   = 3'd7;

  // 0.25 s per pattern step at 50 MHz.
  localparam int unsigned TICK_CYCLES_DEFAULT = 12_500_000;

endpackage : led_pkg
`default_nettype wire

// File: rtl/led_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : led_tick_gen
// Description : Free-running step-period counter. Counts 0..TICK_CYCLES-1 and
//               flags the last count; a synchronous clear restarts the period.
// Revision    : 1.0 - initial release
// Ports       :
//   clk  in  1  system clock
//   rst  in  1  asynchronous active-low reset
//   clr  in  1  synchronous restart of the period (count forced to 0)
//   tick out 1  high while the registered count equals TICK_CYCLES-1
// ============================================================================
module led_tick_gen
  import led_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = TICK_CYCLES_DEFAULT  // must be >= 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned     CNT_W    = $clog2(TICK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Compare on the registered count; the consumer decides whether a clear
  // in the same cycle suppresses the step.
  assign tick = (cnt_q == CNT_LAST);

endmodule : led_tick_gen
`default_nettype wire

// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_gen
// Description : Drives the LED bank with one of eight animated patterns chosen
//               by the held 3-bit mode. Patterns advance once per tick period;
//               any mode change reloads the pattern and restarts the period.
// Revision    : 1.0 - initial release
// Ports       :
//   clk  in  1      system clock
//   rst  in  1      asynchronous active-low reset
//   mode in  3      pattern select (held value from the key counter)
//   led  out LED_W  registered LED drive, 1 = on
//   step out 1      one-cycle pulse when led takes a stepped value
// ============================================================================
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int unsigned LED_W       = 8,                   // must be >= 2
  parameter int unsigned TICK_CYCLES = TICK_CYCLES_DEFAULT  // must be >= 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  output logic [LED_W-1:0] led,
  output logic             step
);

  localparam logic [LED_W-1:0] ALL_ONES = '1;
  localparam logic [LED_W-1:0] LSB_ONE  = LED_W'(1);
  localparam logic [LED_W-1:0] MSB_ONE  = {1'b1, {(LED_W-1){1'b0}}};

  mode_t            mode_q, mode_d;
  logic             dir_q, dir_d;      // bounce direction, 0 = toward MSB
  logic [LED_W-1:0] led_q, led_d;
  logic             step_q, step_d;

  logic mode_chg;
  logic tick;
  logic go_right;

  function automatic logic [LED_W-1:0] init_val(input mode_t m);
    case (m)
      MODE_ON, MODE_BLINK: init_val = ALL_ONES;
      MODE_RUN_L:          init_val = LSB_ONE;
      MODE_RUN_R:          init_val = MSB_ONE;
      MODE_BOUNCE:         init_val = LSB_ONE;
      default:             init_val = '0;   // OFF, COUNT, FILL
    endcase
  endfunction

  assign mode_chg = (mode != mode_q);

  led_tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (mode_chg),
    .tick(tick)
  );

  // Bounce turns around at either end. Deciding from the current position
  // (not only dir_q) means an endpoint can never shift the dot out of range.
  assign go_right = dir_q ? !led_q[0] : led_q[LED_W-1];

  always_comb begin
    mode_d = mode_q;
    dir_d  = dir_q;
    led_d  = led_q;
    step_d = 1'b0;

    if (mode_chg) begin
      mode_d = mode;
      led_d  = init_val(mode);
      dir_d  = 1'b0;
    end else if (tick) begin
      step_d = 1'b1;
      case (mode_q)
        MODE_OFF: led_d = '0;
        MODE_ON:  led_d = ALL_ONES;
        MODE_RUN_L: begin
          // A lost dot (not one-hot) is re-seeded rather than rotated.
          if ($onehot(led_q)) led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
          else                led_d = LSB_ONE;
        end
        MODE_RUN_R: begin
          if ($onehot(led_q)) led_d = {led_q[0], led_q[LED_W-1:1]};
          else                led_d = MSB_ONE;
        end
        MODE_BOUNCE: begin
          if (!$onehot(led_q)) begin
            led_d = LSB_ONE;
            dir_d = 1'b0;
          end else if (go_right) begin
            led_d = led_q >> 1;
            dir_d = !led_d[0];
          end else begin
            led_d = led_q << 1;
            dir_d = led_d[LED_W-1];
          end
        end
        MODE_BLINK: led_d = (led_q == ALL_ONES) ? '0 : ALL_ONES;
        MODE_COUNT: led_d = led_q + LSB_ONE;
        MODE_FILL: begin
          // Only thermometer codes (0, 1, 3, ..., all-ones) are legal here.
          if ((led_q == ALL_ONES) || ((led_q & (led_q + LSB_ONE)) != '0)) begin
            led_d = '0;
          end else begin
            led_d = (led_q << 1) | LSB_ONE;
          end
        end
        default: led_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= MODE_OFF;
      dir_q  <= 1'b0;
      led_q  <= '0;
      step_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      dir_q  <= dir_d;
      led_q  <= led_d;
      step_q <= step_d;
    end
  end

  assign led  = led_q;
  assign step = step_q;

endmodule : led_pattern_gen
`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_pattern_gen
// Description : Self-checking bench for led_pattern_gen (LED_W = 8,
//               TICK_CYCLES = 4). A reference model computes each pattern
//               value from its step index; expected cycle results are queued
//               at every clock edge and a monitor compares them mid-cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pattern_gen;

  localparam int W    = 8;
  localparam int TICK = 4;

  logic         clk  = 1'b0;
  logic         rst  = 1'b0;
  logic [2:0]   mode = 3'd0;
  logic [W-1:0] led;
  logic         step;

  led_pattern_gen #(
    .LED_W      (W),
    .TICK_CYCLES(TICK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mode(mode),
    .led (led),
    .step(step)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] led;
    logic         step;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Model state: current mode, steps taken since reload, cycles in period.
  int m_mode = 0;
  int m_k    = 0;
  int m_cnt  = 0;

  // Pattern value after k steps from the initial value of mode m.
  function automatic logic [W-1:0] seq_val(int m, int k);
    int p;
    int pos;
    case (m)
      0: return '0;
      1: return '1;
      2: return W'(1 << (k % W));
      3: return W'(1 << (W - 1 - (k % W)));
      4: begin
        p   = k % (2 * W - 2);
        pos = (p < W) ? p : (2 * W - 2 - p);
        return W'(1 << pos);
      end
      5: return ((k % 2) == 0) ? '1 : '0;
      6: return W'(k % (1 << W));
      7: begin
        p = k % (W + 1);
        return W'((1 << p) - 1);
      end
      default: return '0;
    endcase
  endfunction

  task automatic check_val(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (mode=%0d t=%0t)", name, act, exp, m_mode, $time);
    end
  endtask

  // Reference model: one expected result per clock edge.
  always @(posedge clk or negedge rst) begin : model
    int   nm, nk, nc;
    logic ns;
    exp_t e;
    if (!rst) begin
      nm = 0; nk = 0; nc = 0; ns = 1'b0;
    end else begin
      nm = m_mode; nk = m_k; nc = m_cnt + 1; ns = 1'b0;
      if (int'(mode) != m_mode) begin
        nm = int'(mode); nk = 0; nc = 0;
      end else if (nc == TICK) begin
        nc = 0; nk = m_k + 1; ns = 1'b1;
      end
    end
    m_mode <= nm;
    m_k    <= nk;
    m_cnt  <= nc;
    // Reset assertion happens while clk is low, so only clock edges push.
    if (clk) begin
      e.led  = seq_val(nm, nk);
      e.step = ns;
      exp_q.push_back(e);
    end
  end

  // Monitor: compares mid-cycle, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL queue_empty: got no expected entry at t=%0t", $time);
    end else begin
      e = exp_q.pop_front();
      check_val("led", led, e.led);
      check_val("step", step, e.step);
    end
  end

  // Advance n edges, then settle 2 ns after the last one.
  task automatic cycles(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_mode(int m, int hold);
    mode = 3'(m);
    cycles(hold);
  endtask

  task automatic do_reset(int m_during, int m_after);
    @(negedge clk);
    #2;
    rst  = 1'b0;
    mode = 3'(m_during);
    #1;
    check_val("async_rst_led", led, 0);
    check_val("async_rst_step", step, 0);
    cycles(2);
    rst  = 1'b1;
    mode = 3'(m_after);
  endtask

  initial begin
    #500_000;
    $display("FAIL timeout: got no finish expected finish by t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst  = 1'b0;
    mode = 3'd0;
    @(posedge clk);
    #2;
    cycles(3);
    rst = 1'b1;
    cycles(20);                 // OFF held after reset

    set_mode(2, 40);            // RUN_L
    set_mode(4, 64);            // BOUNCE
    set_mode(6, 256 * TICK + 8);// COUNT full wrap
    set_mode(7, 48);            // FILL

    // Change BLINK -> ON exactly where the tick would fire.
    set_mode(5, 10);
    for (int i = 0; i < 2 * TICK && m_cnt != TICK - 1; i++) cycles(1);
    set_mode(1, 10);

    // Back-to-back changes; timing restarts from the last one.
    set_mode(3, 1);
    set_mode(2, 1);
    set_mode(3, 12);

    // Reset in RUN_L while led = 0x10, release with mode 2.
    set_mode(2, 1);
    for (int i = 0; i < 8 * TICK && seq_val(m_mode, m_k) != 8'h10; i++) cycles(1);
    do_reset(2, 2);
    cycles(12);

    // Randomised mode sequences with occasional resets.
    for (int s = 0; s < 200; s++) begin
      if ($urandom_range(0, 19) == 0) begin
        do_reset(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        cycles(int'($urandom_range(1, 6)));
      end else begin
        set_mode(int'($urandom_range(0, 7)), int'($urandom_range(1, 14)));
      end
    end

    cycles(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_led_pattern_gen
`default_nettype wire
